// File: rtl/instruction_cache_fifo.sv
// Fetch-side instruction FIFO exposing the four oldest words to the scheduler; push visible one cycle after its edge.
// Backpressure: push_ready drops when full after this cycle's consume, or during a flush; size_next is combinational.
module instruction_cache_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                                  main_clk,
    input  logic                                  main_reset,
    input  logic                                  push_valid,
    input  logic [WIDTH-1:0]                      push_data,
    output logic                                  push_ready,
    input  logic [2:0]                            consume_count,
    input  logic                                  flush,
    output logic [$clog2(DEPTH):0]                fifo_instruction_cache_size,
    output logic [$clog2(DEPTH):0]                fifo_instruction_cache_size_next,
    output logic [3:0][WIDTH-1:0]                 head_words,
    output logic [3:0]                            head_words_valid
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [SW-1:0] size_q, size_d;

    logic [SW-1:0] consume_ext;
    logic [SW-1:0] consume_eff;
    logic [SW-1:0] size_after_consume;
    logic          push_fire;

    assign consume_ext        = {{(SW-3){1'b0}}, consume_count};
    // Over-consumption is a scheduler bug; clamp so the pointers never overtake tail.
    assign consume_eff        = (consume_ext > size_q) ? size_q : consume_ext;
    assign size_after_consume = size_q - consume_eff;

    assign push_ready = !flush && (size_after_consume < SW'(DEPTH));
    assign push_fire  = push_valid && push_ready;

    always_comb begin
        head_d = head_q + consume_eff[AW-1:0];
        tail_d = tail_q;
        size_d = size_q;
        if (main_reset) begin
            head_d = '0;
            tail_d = '0;
            size_d = '0;
        end else if (flush) begin
            // Whatever the scheduler took this cycle is still retired before the queue empties.
            tail_d = head_d;
            size_d = '0;
        end else begin
            tail_d = tail_q + AW'(push_fire);
            size_d = size_after_consume + SW'(push_fire);
        end
    end

    assign fifo_instruction_cache_size_next = size_d;
    assign fifo_instruction_cache_size      = size_q;

    always_ff @(posedge main_clk) begin
        head_q <= head_d;
        tail_q <= tail_d;
        size_q <= size_d;
    end

    always_ff @(posedge main_clk) begin
        if (!main_reset && push_fire) begin
            mem[tail_q] <= push_data;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_head
        logic [AW-1:0] rd_idx;
        assign rd_idx              = head_q + AW'(i);
        assign head_words[i]       = mem[rd_idx];
        assign head_words_valid[i] = (size_q > SW'(i));
    end

    always_ff @(posedge main_clk) begin
        if (!main_reset) begin
            assert (consume_ext <= size_q)
                else $warning("consume_count %0d exceeds occupancy %0d, clamped", consume_count, size_q);
            assert ((tail_q - head_q) == size_q[AW-1:0])
                else $error("pointer/occupancy mismatch head=%0d tail=%0d size=%0d", head_q, tail_q, size_q);
        end
    end

endmodule

// File: tb/tb_instruction_cache_fifo.sv
// Directed bench for instruction_cache_fifo: reset, ordering, full-with-drain, wrap, flush, over-consume.
module tb_instruction_cache_fifo;

    localparam int WIDTH = 16;
    localparam int DEPTH = 16;

    logic              main_clk;
    logic              main_reset;
    logic              push_valid;
    logic [WIDTH-1:0]  push_data;
    logic              push_ready;
    logic [2:0]        consume_count;
    logic              flush;
    logic [4:0]        size;
    logic [4:0]        size_next;
    logic [3:0][WIDTH-1:0] head_words;
    logic [3:0]        head_words_valid;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] q[$];

    instruction_cache_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .main_clk                         (main_clk),
        .main_reset                       (main_reset),
        .push_valid                       (push_valid),
        .push_data                        (push_data),
        .push_ready                       (push_ready),
        .consume_count                    (consume_count),
        .flush                            (flush),
        .fifo_instruction_cache_size      (size),
        .fifo_instruction_cache_size_next (size_next),
        .head_words                       (head_words),
        .head_words_valid                 (head_words_valid)
    );

    initial main_clk = 1'b0;
    always #5 main_clk = ~main_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge main_clk);
        #1;
    endtask

    task automatic push_word(input logic [WIDTH-1:0] d);
        push_valid = 1'b1;
        push_data  = d;
        tick();
        push_valid = 1'b0;
        q.push_back(d);
    endtask

    task automatic drain_step(input int n, input string tag);
        logic [3:0] exp_vld;
        consume_count = 3'(n);
        #1;
        exp_vld = '0;
        for (int i = 0; i < 4; i++) begin
            if (i < q.size()) begin
                exp_vld[i] = 1'b1;
                chk({tag, "_word"}, 32'(head_words[i]), 32'(q[i]));
            end
        end
        chk({tag, "_vld"}, 32'(head_words_valid), 32'(exp_vld));
        chk({tag, "_next"}, 32'(size_next), 32'(q.size() - n));
        tick();
        consume_count = '0;
        for (int i = 0; i < n; i++) void'(q.pop_front());
    endtask

    initial begin
        main_reset    = 1'b1;
        push_valid    = 1'b1;
        push_data     = 16'hAAAA;
        consume_count = '0;
        flush         = 1'b0;
        tick();
        tick();
        chk("rst_size", 32'(size), 32'd0);
        chk("rst_size_next", 32'(size_next), 32'd0);
        chk("rst_ready", 32'(push_ready), 32'd1);
        chk("rst_vld", 32'(head_words_valid), 32'h0);

        // First push right at reset release.
        main_reset = 1'b0;
        push_data  = 16'hBEEF;
        #1;
        chk("rel_next", 32'(size_next), 32'd1);
        tick();
        push_valid = 1'b0;
        chk("rel_size", 32'(size), 32'd1);
        chk("rel_hw0", 32'(head_words[0]), 32'hBEEF);
        chk("rel_vld", 32'(head_words_valid), 32'h1);
        consume_count = 3'd1;
        tick();
        consume_count = '0;
        chk("rel_empty", 32'(size), 32'd0);

        // Six words, then consume four of them.
        for (int k = 1; k <= 6; k++) push_word(16'(k * 16'h0101 + 16'h1010));
        consume_count = 3'd4;
        #1;
        chk("c4_size", 32'(size), 32'd6);
        chk("c4_hw0", 32'(head_words[0]), 32'h1111);
        chk("c4_hw1", 32'(head_words[1]), 32'h1212);
        chk("c4_hw2", 32'(head_words[2]), 32'h1313);
        chk("c4_hw3", 32'(head_words[3]), 32'h1414);
        chk("c4_next", 32'(size_next), 32'd2);
        tick();
        consume_count = '0;
        chk("c4_after_size", 32'(size), 32'd2);
        chk("c4_after_hw0", 32'(head_words[0]), 32'h1515);
        chk("c4_after_vld", 32'(head_words_valid), 32'h3);
        consume_count = 3'd2;
        tick();
        consume_count = '0;
        q.delete();
        chk("c4_empty", 32'(size), 32'd0);

        // Fill to DEPTH; head and tail now sit at index 7.
        for (int k = 0; k < 16; k++) push_word(16'h2000 + 16'(k));
        push_valid = 1'b1;
        push_data  = 16'h2100;
        #1;
        chk("full_size", 32'(size), 32'd16);
        chk("full_ready", 32'(push_ready), 32'd0);
        chk("full_next", 32'(size_next), 32'd16);
        consume_count = 3'd1;
        #1;
        chk("full_drain_ready", 32'(push_ready), 32'd1);
        chk("full_drain_next", 32'(size_next), 32'd16);
        chk("full_drain_hw0", 32'(head_words[0]), 32'h2000);
        tick();
        push_valid    = 1'b0;
        consume_count = '0;
        void'(q.pop_front());
        q.push_back(16'h2100);
        chk("full_again_size", 32'(size), 32'd16);

        // Head at 8: drain 2 brings it to 10, then 14 shows entries 14,15,0,1.
        drain_step(2, "wrap_a");
        drain_step(4, "wrap_b");
        drain_step(4, "wrap_c");
        drain_step(4, "wrap_d");
        drain_step(2, "wrap_e");
        chk("wrap_empty", 32'(size), 32'd0);

        // Flush with nine entries, a push and a consume of three in the same cycle.
        for (int k = 0; k < 9; k++) push_word(16'h3000 + 16'(k));
        flush         = 1'b1;
        push_valid    = 1'b1;
        push_data     = 16'h3999;
        consume_count = 3'd3;
        #1;
        chk("fl_ready", 32'(push_ready), 32'd0);
        chk("fl_next", 32'(size_next), 32'd0);
        tick();
        flush         = 1'b0;
        push_valid    = 1'b0;
        consume_count = '0;
        q.delete();
        #1;
        chk("fl_size", 32'(size), 32'd0);
        chk("fl_vld", 32'(head_words_valid), 32'h0);
        push_word(16'h4444);
        chk("fl_push_size", 32'(size), 32'd1);
        chk("fl_push_hw0", 32'(head_words[0]), 32'h4444);
        chk("fl_push_vld", 32'(head_words_valid), 32'h1);

        // Over-consume: four requested with two present, plus a push.
        push_word(16'h5555);
        consume_count = 3'd4;
        push_valid    = 1'b1;
        push_data     = 16'h6666;
        #1;
        chk("oc_ready", 32'(push_ready), 32'd1);
        chk("oc_next", 32'(size_next), 32'd1);
        tick();
        consume_count = '0;
        push_valid    = 1'b0;
        chk("oc_size", 32'(size), 32'd1);
        chk("oc_hw0", 32'(head_words[0]), 32'h6666);

        // Reset beats a simultaneous flush/push/consume.
        push_word(16'h7777);
        main_reset    = 1'b1;
        flush         = 1'b1;
        push_valid    = 1'b1;
        consume_count = 3'd1;
        tick();
        main_reset    = 1'b0;
        flush         = 1'b0;
        push_valid    = 1'b0;
        consume_count = '0;
        #1;
        chk("mrst_size", 32'(size), 32'd0);
        chk("mrst_vld", 32'(head_words_valid), 32'h0);
        chk("mrst_ready", 32'(push_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
